// File: rtl/trit_resolve_scheduler.sv
// trit_resolve_scheduler: shares one NeutralTrinaryUnit resolver between
// NUM_REQ requesters. Requests are granted round-robin, the trit is loaded
// through the unit's reset/initial-state port, and the result is returned
// once the resolved output has been identical and non-ambiguous for
// STABLE_CYCLES consecutive samples.
// Optional feature: define TRIT_SCHED_TIMEOUT_EN to build the SETTLE timeout
// (abandon after TIMEOUT cycles, respond with 2'b10 and resp_timeout = 1).
module trit_resolve_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 15,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_state,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [1:0]           resp_state,
  output logic                 resp_timeout,
  output logic                 unit_rst,
  output logic [1:0]           unit_init_state,
  input  logic [1:0]           unit_resolved_state,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [1:0]       TRIT_AMB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  hold_id_q, hold_id_d;
  logic [1:0]       hold_state_q, hold_state_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [1:0]       resp_state_q, resp_state_d;

`ifdef TRIT_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] cyc_upd;
  logic             resp_timeout_q, resp_timeout_d;
`endif

  // Round-robin search variables.
  int              cand;
  logic [ID_W-1:0] cand_id;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic [CNT_W-1:0] stable_upd;
  logic [1:0]       sample;

  // Pick the first valid requester after last_grant, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  // Grant is only offered from IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found && !rst) req_ready = NUM_REQ'(1) << win_id;
  end

  // Next-state and datapath updates for the IDLE/LOAD/SETTLE/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_id_d    = hold_id_q;
    hold_state_d = hold_state_q;
    prev_d       = prev_q;
    stable_cnt_d = stable_cnt_q;
    resp_id_d    = resp_id_q;
    resp_state_d = resp_state_q;
    sample       = unit_resolved_state;
    stable_upd   = stable_cnt_q;
`ifdef TRIT_SCHED_TIMEOUT_EN
    cyc_cnt_d      = cyc_cnt_q;
    cyc_upd        = cyc_cnt_q;
    resp_timeout_d = resp_timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|(req_valid & req_ready)) begin
          hold_id_d    = win_id;
          hold_state_d = req_state[{win_id, 1'b0} +: 2];
          last_grant_d = win_id;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        prev_d       = 2'b00;
        stable_cnt_d = '0;
`ifdef TRIT_SCHED_TIMEOUT_EN
        cyc_cnt_d    = '0;
`endif
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        // A run of identical non-ambiguous samples builds stable_upd.
        if (sample == TRIT_AMB) begin
          stable_upd = '0;
        end else if (sample == prev_q && stable_cnt_q != '0) begin
          stable_upd = (stable_cnt_q == CNT_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
        end else begin
          stable_upd = CNT_W'(1);
        end
        stable_cnt_d = stable_upd;
        prev_d       = sample;
`ifdef TRIT_SCHED_TIMEOUT_EN
        cyc_upd   = (cyc_cnt_q == CNT_MAX) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
        cyc_cnt_d = cyc_upd;
`endif
        // Stability is tested first so it wins over a coincident timeout.
        if (stable_upd == STABLE_N) begin
          state_d        = S_RESP;
          resp_id_d      = hold_id_q;
          resp_state_d   = sample;
`ifdef TRIT_SCHED_TIMEOUT_EN
          resp_timeout_d = 1'b0;
        end else if (cyc_upd >= TIMEOUT_N) begin
          state_d        = S_RESP;
          resp_id_d      = hold_id_q;
          resp_state_d   = TRIT_AMB;
          resp_timeout_d = 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= LAST_ID;
      hold_id_q      <= '0;
      hold_state_q   <= 2'b00;
      prev_q         <= 2'b00;
      stable_cnt_q   <= '0;
      resp_id_q      <= '0;
      resp_state_q   <= 2'b00;
`ifdef TRIT_SCHED_TIMEOUT_EN
      cyc_cnt_q      <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      hold_id_q      <= hold_id_d;
      hold_state_q   <= hold_state_d;
      prev_q         <= prev_d;
      stable_cnt_q   <= stable_cnt_d;
      resp_id_q      <= resp_id_d;
      resp_state_q   <= resp_state_d;
`ifdef TRIT_SCHED_TIMEOUT_EN
      cyc_cnt_q      <= cyc_cnt_d;
      resp_timeout_q <= resp_timeout_d;
`endif
    end
  end

  // Output decode from the registered state.
  always_comb begin
    resp_valid      = (state_q == S_RESP);
    busy            = (state_q != S_IDLE);
    unit_rst        = (state_q == S_IDLE) || (state_q == S_LOAD);
    unit_init_state = hold_state_q;
    resp_id         = resp_id_q;
    resp_state      = resp_state_q;
`ifdef TRIT_SCHED_TIMEOUT_EN
    resp_timeout    = resp_timeout_q;
`else
    resp_timeout    = 1'b0;
`endif
  end

endmodule

// File: doc/trit_resolve_scheduler.md
# trit_resolve_scheduler

Shares one `NeutralTrinaryUnit` resolver between `NUM_REQ` requesters. Each request carries a 2-bit trit. The block grants requests round-robin and loads the trit into the unit through the unit's reset/initial-state port. It then waits until the resolved output is stable and non-ambiguous, and returns the result with the requester ID. It sits between the requester fabric and the single resolver instance.

## Interface
Trit encoding: `2'b00` = 0, `2'b01` = +, `2'b11` = −, `2'b10` = ambiguous (+/−).

Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..16
- `STABLE_CYCLES`, 2 — consecutive identical non-ambiguous samples required to accept a result, ≥1
- `TIMEOUT`, 15 — maximum SETTLE cycles before the request is abandoned, > `STABLE_CYCLES`
- `ID_W` — derived, `$clog2(NUM_REQ)`

Ports:
- `clk` in 1 — single clock; all logic on the rising edge
- `rst` in 1 — asynchronous, active-high reset
- `req_valid` in `NUM_REQ` — request pending, one bit per requester
- `req_state` in `2*NUM_REQ` — requester i's trit at `[2i+1:2i]`
- `req_ready` out `NUM_REQ` — one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `resp_valid` out 1 — result available
- `resp_ready` in 1 — consumer accepts the result
- `resp_id` out `ID_W` — index of the served requester
- `resp_state` out 2 — resolved trit
- `resp_timeout` out 1 — result was abandoned; `resp_state` = `2'b10`
- `unit_rst` out 1 — drives the resolver's `rst`
- `unit_init_state` out 2 — drives the resolver's `initial_state`
- `unit_resolved_state` in 2 — from the resolver's `resolved_state`
- `busy` out 1 — FSM is not in IDLE

## Operation
FSM states: IDLE → LOAD → SETTLE → RESP → IDLE.

IDLE:
- `unit_rst` = 1.
- The winner is the first requester with `req_valid` set, searching from `last_grant+1` modulo `NUM_REQ`.
- `req_ready` = one-hot of the winner (combinational from `req_valid`); all zero if there are no requests.
- On transfer, capture the ID and trit into the holding registers, update `last_grant`, and go to LOAD.

LOAD:
- One cycle.
- `unit_rst` = 1 and `unit_init_state` = the captured trit.
- Clear `prev`, `stable_cnt` and `cyc_cnt`, then go to SETTLE.

SETTLE:
- `unit_rst` = 0; `unit_init_state` holds the captured trit.
- `cyc_cnt` increments every cycle.
- Each cycle, sample `s` = `unit_resolved_state`:
  - if `s` = `2'b10`, `stable_cnt` ← 0;
  - else if `s` = `prev` and `stable_cnt` ≠ 0, `stable_cnt` ← `stable_cnt`+1;
  - else `stable_cnt` ← 1.
  - `prev` ← `s`.
- Stable exit: when the updated `stable_cnt` equals `STABLE_CYCLES`, go to RESP with `resp_state` = `s` and `resp_timeout` = 0.
- Timeout exit (see Configuration): when `cyc_cnt` reaches `TIMEOUT` with no stable exit, go to RESP with `resp_state` = `2'b10` and `resp_timeout` = 1.
- If both exits occur on the same cycle, stability wins.

RESP:
- `resp_valid` = 1; `resp_id`, `resp_state` and `resp_timeout` are held stable until `resp_ready`.
- `unit_rst` = 0.
- On handshake, go to IDLE.
- No grant is issued in the same cycle as a response handshake.

Arithmetic:
- Counters are wide enough for `TIMEOUT` and saturate; they never wrap.
- The `last_grant` pointer wraps from `NUM_REQ-1` to 0.

## Timing
- Reset values:
  - state = IDLE
  - `unit_rst` = 1, `unit_init_state` = `2'b00`
  - `req_ready` = 0 (while `rst` is high)
  - `resp_valid` = 0, `resp_id` = 0, `resp_state` = `2'b00`, `resp_timeout` = 0
  - `busy` = 0
  - `last_grant` = `NUM_REQ-1`, so the first search starts at requester 0.
- Reset asserted mid-operation: the in-flight request is dropped with no response, and the FSM returns to IDLE asynchronously.
- Latency: grant at cycle G, LOAD at G+1, SETTLE from G+2.
  - If the resolver is stable from G+2, `resp_valid` rises at G+2+`STABLE_CYCLES`.
  - Worst case, `resp_valid` rises at G+2+`TIMEOUT`.
- Throughput: one request per at least `STABLE_CYCLES`+3 cycles; consumer backpressure adds cycles.
- `req_valid` must stay high until the transfer. A requester that drops `req_valid` before its grant loses its slot without error.

## Configuration
- Macro: `TRIT_SCHED_TIMEOUT_EN`.
- Defined: the timeout exit and the `cyc_cnt` counter are built as described.
- Undefined: no timeout; SETTLE waits indefinitely for stability; `resp_timeout` is tied to 0.

## Test plan
- Requester 0 sends trit `2'b01`, resolver holds `2'b01` → `req_ready` = `4'b0001`; `unit_rst` is low from G+2; `resp_valid` at G+4 with `resp_id` = 0, `resp_state` = `2'b01`, `resp_timeout` = 0.
- Requesters 1, 2 and 3 all valid continuously → grants in order 1, 2, 3, 1 with one-hot `req_ready`; no requester is skipped.
- Resolver outputs `10, 01, 11, 11` → `resp_state` = `2'b11`, accepted on the second `11` sample.
- Resolver stuck at `2'b10`, macro defined → `resp_valid` at G+17 with `resp_state` = `2'b10`, `resp_timeout` = 1. Macro undefined → `busy` stays 1 and there is no response.
- `resp_ready` held low for 5 cycles → `resp_valid`, `resp_id` and `resp_state` stay constant; no new grant until the handshake.
- `rst` pulsed during SETTLE → all outputs return to their reset values immediately; no response for the dropped request; the next grant goes to requester 0.
